// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter_if
// Purpose  : Fetch, load/store and RAM-side signals of the shared-RAM arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_data_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_ack, ls_rdata, ls_err,
        output mem_cs, mem_we, mem_addr, mem_data_valid, mem_wdata,
        input  mem_data_ready, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_ack, ls_rdata, ls_err,
        input  mem_cs, mem_we, mem_addr, mem_data_valid, mem_wdata,
        output mem_data_ready, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Purpose  : Round-robin fetch/load-store arbiter and RAM access sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_CNT_MAX  = 8'hFF;

    state_t            r_state, w_state_nx;
    logic              r_last_b, w_last_b_nx;
    logic              r_grant_b, w_grant_b_nx;
    logic [7:0]        r_cnt, w_cnt_nx;
    logic              r_sync1, r_sync2;
    logic              r_mem_cs, w_cs_nx;
    logic              r_mem_we, w_we_nx;
    logic              r_mem_dv, w_dv_nx;
    logic [ADDR_W-1:0] r_mem_addr, w_addr_nx;
    logic [DATA_W-1:0] r_mem_wdata, w_wdata_nx;
    logic              r_if_ack, w_if_ack_nx, r_if_err, w_if_err_nx;
    logic              r_ls_ack, w_ls_ack_nx, r_ls_err, w_ls_err_nx;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nx, r_ls_rdata, w_ls_rdata_nx;

    logic              w_pick_b;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_done;
    logic              w_fail;
    logic [DATA_W-1:0] w_data;

    // On a tie the port that did not win last time is served.
    assign w_pick_b   = bus.ls_req & (~bus.if_req | ~r_last_b);
    assign w_req_addr = w_pick_b ? bus.ls_addr : bus.if_addr;

    always_comb begin
        w_state_nx    = r_state;
        w_last_b_nx   = r_last_b;
        w_grant_b_nx  = r_grant_b;
        w_cnt_nx      = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 8'd1;
        w_cs_nx       = r_mem_cs;
        w_we_nx       = r_mem_we;
        w_dv_nx       = 1'b0;
        w_addr_nx     = r_mem_addr;
        w_wdata_nx    = r_mem_wdata;
        w_done        = 1'b0;
        w_fail        = 1'b0;
        w_data        = '0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    w_grant_b_nx = w_pick_b;
                    w_last_b_nx  = w_pick_b;
                    w_addr_nx    = w_req_addr;
                    w_wdata_nx   = w_pick_b ? bus.ls_wdata : '0;
                    w_cnt_nx     = '0;
                    if (w_req_addr[1:0] != 2'b00) begin
                        w_state_nx = S_ERR;
                    end else begin
                        w_state_nx = S_ACCESS;
                        w_cs_nx    = 1'b1;
                        w_we_nx    = w_pick_b & bus.ls_we;
                        w_dv_nx    = w_pick_b & bus.ls_we;
                    end
                end
            end
            S_ACCESS: begin
                if (r_sync2 || (r_cnt == c_CNT_LAST)) begin
                    w_done     = 1'b1;
                    w_fail     = ~r_sync2;
                    w_data     = r_sync2 ? bus.mem_rdata : '0;
                    w_state_nx = S_RELEASE;
                    w_cs_nx    = 1'b0;
                    w_we_nx    = 1'b0;
                    w_cnt_nx   = '0;
                end
            end
            S_RELEASE: begin
                // A RAM that never drops ready is abandoned silently.
                if (!r_sync2 || (r_cnt == c_CNT_LAST))
                    w_state_nx = S_IDLE;
            end
            S_ERR: begin
                w_done     = 1'b1;
                w_fail     = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase

        w_if_ack_nx   = w_done & ~r_grant_b;
        w_if_err_nx   = w_done & ~r_grant_b & w_fail;
        w_ls_ack_nx   = w_done & r_grant_b;
        w_ls_err_nx   = w_done & r_grant_b & w_fail;
        w_if_rdata_nx = (w_done && !r_grant_b) ? w_data : r_if_rdata;
        w_ls_rdata_nx = (w_done && r_grant_b)  ? w_data : r_ls_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_b    <= 1'b1;
            r_grant_b   <= 1'b0;
            r_cnt       <= '0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_dv    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_err    <= 1'b0;
            r_ls_ack    <= 1'b0;
            r_ls_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_last_b    <= w_last_b_nx;
            r_grant_b   <= w_grant_b_nx;
            r_cnt       <= w_cnt_nx;
            r_sync1     <= bus.mem_data_ready;
            r_sync2     <= r_sync1;
            r_mem_cs    <= w_cs_nx;
            r_mem_we    <= w_we_nx;
            r_mem_dv    <= w_dv_nx;
            r_mem_addr  <= w_addr_nx;
            r_mem_wdata <= w_wdata_nx;
            r_if_ack    <= w_if_ack_nx;
            r_if_err    <= w_if_err_nx;
            r_ls_ack    <= w_ls_ack_nx;
            r_ls_err    <= w_ls_err_nx;
            r_if_rdata  <= w_if_rdata_nx;
            r_ls_rdata  <= w_ls_rdata_nx;
        end
    end

    assign bus.mem_cs         = r_mem_cs;
    assign bus.mem_we         = r_mem_we;
    assign bus.mem_data_valid = r_mem_dv;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.if_ack         = r_if_ack;
    assign bus.if_err         = r_if_err;
    assign bus.if_rdata       = r_if_rdata;
    assign bus.ls_ack         = r_ls_ack;
    assign bus.ls_err         = r_ls_err;
    assign bus.ls_rdata       = r_ls_rdata;
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter with a simple RAM model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 255;

    typedef struct {
        bit          port_b;
        logic [31:0] rdata;
        bit          err;
        bit          chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    bit   cs_seen = 1'b0;
    bit   ram_stuck = 1'b0;
    int   wr_cnt = 0;
    logic [31:0] ram [0:255];

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: ready one cycle after chip select, dropped once chip select falls.
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we && bus.mem_data_valid) begin
            ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_cs && !ram_stuck) begin
            bus.mem_data_ready <= 1'b1;
            bus.mem_rdata      <= ram[bus.mem_addr[9:2]];
        end else if (!bus.mem_cs) begin
            bus.mem_data_ready <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit port_b, input logic [31:0] rdata, input bit err, input bit chk_data);
        exp_t e;
        e.port_b = port_b; e.rdata = rdata; e.err = err; e.chk_data = chk_data;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(bus.if_ack || bus.ls_ack) && cycles < budget);
        if (!(bus.if_ack || bus.ls_ack)) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_wait: no ack after %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_cs(input int budget);
        int k = 0;
        while (!bus.mem_cs && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("cs_wait", bus.mem_cs, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_acks"}, {bus.if_ack, bus.if_err, bus.ls_ack, bus.ls_err}, 0);
        check({tag, "_rdata"}, {bus.if_rdata, bus.ls_rdata}, 0);
        check({tag, "_mem_ctl"}, {bus.mem_cs, bus.mem_we, bus.mem_data_valid, bus.mem_addr}, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    // Monitor: pops the scoreboard on every ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_cs) cs_seen = 1'b1;
            if (bus.if_ack || bus.ls_ack) begin
                check("ack_exclusive", bus.if_ack & bus.ls_ack, 0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: if_ack=%0b ls_ack=%0b, required none", bus.if_ack, bus.ls_ack);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_port", bus.ls_ack, e.port_b);
                    check("ack_err", e.port_b ? bus.ls_err : bus.if_err, e.err);
                    if (e.chk_data)
                        check("ack_rdata", e.port_b ? bus.ls_rdata : bus.if_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0, c1, n;
        int   wr_base;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'hDEADBEEF;
        bus.if_req = 0; bus.if_addr = '0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.mem_data_ready = 0; bus.mem_rdata = '0;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 0;

        // Fetch read
        @(negedge clk);
        push(0, 32'hDEADBEEF, 0, 1);
        bus.if_req = 1; bus.if_addr = 15'h0040;
        @(negedge clk);
        check("fetch_cs_rise", bus.mem_cs, 1);
        check("fetch_mem_addr", bus.mem_addr, 15'h0040);
        wait_ack(20, n);
        bus.if_req = 0;
        check("fetch_cs_release", bus.mem_cs, 0);
        repeat (8) @(negedge clk);

        // Store then load
        wr_base = wr_cnt;
        push(1, 32'h0, 0, 0);
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 15'h0100; bus.ls_wdata = 32'h12345678;
        wait_ack(20, n);
        bus.ls_req = 0;
        repeat (8) @(negedge clk);
        push(1, 32'h12345678, 0, 1);
        bus.ls_req = 1; bus.ls_we = 0;
        wait_ack(20, n);
        bus.ls_req = 0;
        repeat (8) @(negedge clk);
        check("store_write_cycles", wr_cnt - wr_base, 1);

        // Contention from reset: A, B, A, B
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        push(0, 32'hDEADBEEF, 0, 1);
        push(1, 32'h12345678, 0, 1);
        push(0, 32'hDEADBEEF, 0, 1);
        push(1, 32'h12345678, 0, 1);
        bus.if_req = 1; bus.if_addr = 15'h0040;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 15'h0100;
        for (int i = 0; i < 4; i++) wait_ack(30, n);
        bus.if_req = 0; bus.ls_req = 0;
        repeat (8) @(negedge clk);

        // Misaligned load
        cs_seen = 0;
        push(1, 32'h0, 1, 1);
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 15'h0102;
        wait_ack(5, n);
        bus.ls_req = 0;
        check("misaligned_latency_ok", n <= 2, 1);
        repeat (4) @(negedge clk);
        check("misaligned_no_cs", cs_seen, 0);

        // Timeout, then normal service
        ram_stuck = 1;
        push(0, 32'h0, 1, 1);
        bus.if_req = 1; bus.if_addr = 15'h0040;
        wait_cs(5);
        c0 = cyc;
        wait_ack(TIMEOUT + 10, n);
        c1 = cyc;
        bus.if_req = 0;
        check("timeout_latency", c1 - c0, TIMEOUT);
        ram_stuck = 0;
        repeat (4) @(negedge clk);
        push(0, 32'hDEADBEEF, 0, 1);
        bus.if_req = 1;
        wait_ack(20, n);
        bus.if_req = 0;
        repeat (8) @(negedge clk);

        // Reset in the middle of an access: A granted first afterwards
        ram_stuck = 1;
        bus.if_req = 1; bus.if_addr = 15'h0040;
        wait_cs(5);
        repeat (3) @(negedge clk);
        rst = 1; bus.if_req = 0;
        @(negedge clk);
        check_zero_outputs("midreset");
        rst = 0;
        ram_stuck = 0;
        push(0, 32'hDEADBEEF, 0, 1);
        push(1, 32'h12345678, 0, 1);
        bus.if_req = 1; bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 15'h0100;
        wait_ack(20, n);
        bus.if_req = 0;
        wait_ack(30, n);
        bus.ls_req = 0;
        repeat (10) @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the shared instruction/data RAM.
- Port A is instruction fetch (read-only). Port B is load/store (read/write).
- Grants one access at a time and drives the RAM's chip_select/write_enable/data_valid sequence.
- Waits on the RAM's data_ready handshake, returns read data, and enforces a timeout so a stuck RAM cannot hang the core.

Parameters:
ADDR_W, 15, byte address width into RAM
DATA_W, 32, data word width
TIMEOUT, 255, max cycles waiting on mem_data_ready level change (8-bit counter)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch byte address, stable while if_req
if_ack  out  1  one-cycle completion pulse
if_rdata  out  DATA_W  fetch data, valid when if_ack
if_err  out  1  with if_ack: timeout or misaligned
ls_req  in  1  load/store request, held until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  byte address, stable while ls_req
ls_wdata  in  DATA_W  store data, stable while ls_req
ls_ack  out  1  one-cycle completion pulse
ls_rdata  out  DATA_W  load data, valid when ls_ack
ls_err  out  1  with ls_ack: timeout or misaligned
mem_cs  out  1  RAM chip_select, registered
mem_we  out  1  RAM write_enable, registered
mem_addr  out  ADDR_W  RAM address, registered
mem_data_valid  out  1  RAM data_valid, registered
mem_wdata  out  DATA_W  RAM write data, registered
mem_data_ready  in  1  RAM ready, asynchronous; double-flop synchronised internally
mem_rdata  in  DATA_W  RAM read data, sampled only when synchronised ready is high

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = B, so A wins the first tie; timeout counter 0.
- Reset mid-access: mem_cs drops at that edge. No ack is issued. Requesters re-request.
- States:
  - IDLE: if any req, choose a winner. Latch addr/we/wdata into mem_* registers.
  - If the latched addr[1:0] != 0: go to ERR, with no RAM access.
  - Otherwise go to ACCESS, with mem_cs = 1, mem_we = ls_we (B only), and mem_data_valid = 1 for a store.
- Arbitration:
  - Single requester: granted.
  - Both requesting: round-robin; the winner is the port opposite last_grant. last_grant updates on every grant.
- ACCESS:
  - mem_data_valid clears after the first ACCESS cycle, so exactly one RAM write edge occurs.
  - mem_cs, mem_addr and mem_we are held.
  - When synchronised ready = 1: capture mem_rdata into the winner's rdata register, pulse the winner's ack for one cycle, go to RELEASE.
  - If the counter reaches TIMEOUT first: pulse ack + err, with rdata = 0, and go to RELEASE.
- RELEASE:
  - mem_cs = 0, mem_we = 0.
  - Wait for synchronised ready = 0, then go to IDLE.
  - Timeout here returns to IDLE silently; it asserts no ack.
- ERR: pulse the winner's ack + err for one cycle (rdata = 0), then IDLE. mem_cs never asserts.
- Timeout counter: cleared on entry to ACCESS and to RELEASE; increments each cycle in those states; saturates.
- Requester rule: req is sampled only in IDLE. A requester deasserts req no later than the cycle after its ack. A req still high at the next IDLE is a new access, which allows back-to-back accesses.
- Minimum spacing: IDLE -> ACCESS -> ... -> RELEASE -> IDLE. No grant is issued while in ACCESS, RELEASE or ERR.
- Only one ack is high per cycle; if_ack and ls_ack are never simultaneous.
- if_rdata and ls_rdata hold their value until that port's next ack.

Test Plan:
- Fetch read:
  - Stimulus: RAM model returns 32'hDEADBEEF at word 0x10. Raise if_req with if_addr = 15'h0040.
  - Required: mem_cs rises the next cycle; one if_ack with if_rdata = 32'hDEADBEEF and if_err = 0; mem_cs drops in RELEASE.
- Store then load:
  - Stimulus: ls_we = 1, ls_addr = 15'h0100, ls_wdata = 32'h12345678. Then a load from the same address.
  - Required: exactly one cycle with mem_cs & mem_we & mem_data_valid; load returns 32'h12345678.
- Contention:
  - Stimulus: if_req and ls_req held high together from reset for four accesses.
  - Required: grant order A, B, A, B; never both acks in the same cycle.
- Misaligned:
  - Stimulus: ls_addr = 15'h0102.
  - Required: ls_ack = 1 and ls_err = 1 within 2 cycles; mem_cs stays 0.
- Timeout:
  - Stimulus: RAM model never raises ready.
  - Required: if_ack + if_err exactly TIMEOUT cycles after entering ACCESS; if_rdata = 0; arbiter returns to IDLE and serves the next request.
- Reset mid-access:
  - Stimulus: assert rst during ACCESS.
  - Required: mem_cs = 0 after that edge, no ack, all outputs 0; the next request is granted to port A.
